logic_unit_seq: RTL and testbench
=================================

// Module: logic_unit_seq
// PURPOSE
//   Parametrised multi-cycle bitwise logic unit: AND/OR/XOR/NOR on two WIDTH-bit operands.
//   Processes one LANE-bit slice per clock, LSB slice first, under a start/busy/done handshake.
//   Also produces a zero flag. Sits beside the ALU as the wide-operand logic path.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   LANE   8   bits processed per cycle; WIDTH % LANE == 0 (LANE == WIDTH allowed)
//   (derived) N = WIDTH/LANE slices; CW = max(1, $clog2(N)) slice-counter width
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      request; sampled only in IDLE
//   op      in   2      00 AND, 01 OR, 10 XOR, 11 NOR
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse: result/zero valid
//   result  out  WIDTH  registered result; held after done until next accepted start
//   zero    out  1      1 iff result == 0; valid with done, held afterwards
// BEHAVIOUR
//   Reset: rst_n sampled low at a clk edge forces all of the following, regardless of state
//     (including mid-RUN): state=IDLE, cnt=0, busy=0, done=0, result=0, zero=1.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: on an edge with start=1, latch a, b and op into internal registers.
//       Same edge: result<=0, zero<=1, cnt<=0, go RUN. start=0: stay in IDLE.
//     RUN: each edge computes slice k=cnt from the latched operands, bits [k*LANE +: LANE].
//       Writes that slice into result; zero<=zero & ~|slice_result.
//       cnt==N-1: go DONE. Otherwise cnt<=cnt+1.
//     DONE: done=1 for exactly one cycle; next edge -> IDLE (cnt<=0).
//   Latency: start sampled at edge E0 -> done high during the cycle after edge E0+N.
//     Throughput: one op per N+2 cycles (start is ignored in DONE).
//   Outputs are fully registered; no combinational path from inputs to outputs.
//     busy = (state==RUN). done = (state==DONE).
//   Changes on a/b/op and start pulses are ignored while in RUN or DONE.
//   NOR is ~(a|b) per bit; XOR is a^b. No arithmetic, no carries between slices.
//   Until done, result shows partially filled slices (upper slices 0). Consumers use done.
//   N==1: RUN lasts one cycle; cnt stays 0.
// TESTING (WIDTH=32, LANE=8 unless noted)
//   1 OR: a=32'h0000_00F0, b=32'h0000_000F, op=01, start 1 cycle
//     -> busy for 4 cycles, then done pulse: result=32'h0000_00FF, zero=0.
//   2 AND to zero: a=32'hFFFF_0000, b=32'h0000_FFFF, op=00
//     -> result=0, zero=1. XOR a=32'hA5A5_A5A5, b=32'hFFFF_FFFF -> 32'h5A5A_5A5A, zero=0.
//     NOR a=0, b=0 -> 32'hFFFF_FFFF.
//   3 Input churn: start op=01 a=1 b=2, then during RUN set a=b=32'hFFFF_FFFF, op=00 and pulse start
//     -> result=32'h3; exactly one done pulse; no new op begins.
//   4 Reset mid-op: rst_n=0 at the 2nd RUN edge
//     -> next cycle busy=0, done=0, result=0, zero=1, state IDLE.
//     A fresh OR 32'h1|32'h0 then yields 32'h1 after 4 cycles.
//   5 Back-to-back: start held high with two operand sets
//     -> done pulses 6 cycles apart; each result matches the operands present at its IDLE sample.
//   6 Param sweep: LANE=32 (N=1) and LANE=4 (N=8), random ops/operands vs a^b/&/|/~| model
//     -> latency N cycles, all results match the model.

Source files
------------

// File: rtl/logic_unit_seq_if.sv
// logic_unit_seq_if: request/operand and result/status bundle for logic_unit_seq.
interface logic_unit_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    modport master(output start, op, a, b, input busy, done, result, zero);
    modport slave(input start, op, a, b, output busy, done, result, zero);
endinterface

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle AND/OR/XOR/NOR on WIDTH-bit operands, one LANE-bit slice per clock.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_seq_if.slave  bus
);
    localparam int N  = WIDTH / LANE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, result;
    logic [1:0]       op_q;
    logic             zero, last;
    logic [LANE-1:0]  sa, sb, slice;
    int               base;
    assign last  = cnt == CW'(N - 1);
    assign base  = int'(cnt) * LANE;
    assign sa    = a_q[base +: LANE];
    assign sb    = b_q[base +: LANE];
    assign slice = op_q == 2'b00 ? sa & sb :
                   op_q == 2'b01 ? sa | sb :
                   op_q == 2'b10 ? sa ^ sb : ~(sa | sb);
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end
    // Operands are captured once so input churn during RUN cannot corrupt later slices.
    always_ff @(posedge clk)
        if (!rst_n) begin
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else if (state == IDLE && bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            op_q   <= bus.op;
            result <= '0;
            zero   <= 1'b1;
            cnt    <= '0;
        end else if (state == RUN) begin
            result[base +: LANE] <= slice;
            zero                 <= zero & ~|slice;
            cnt                  <= last ? cnt : cnt + CW'(1);
        end else if (state == DONE) begin
            cnt <= '0;
        end
    always_comb begin
        bus.busy   = state == RUN;
        bus.done   = state == DONE;
        bus.result = result;
        bus.zero   = zero;
    end
endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: directed checks of logic_unit_seq at LANE=8 (N=4), LANE=4 (N=8) and LANE=32 (N=1).
module tb_logic_unit_seq;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  logic_unit_seq_if #(.WIDTH(32)) if8 ();
  logic_unit_seq_if #(.WIDTH(32)) if4 ();
  logic_unit_seq_if #(.WIDTH(32)) if32 ();
  assign if8.start = start;  assign if8.op = op;  assign if8.a = a;  assign if8.b = b;
  assign if4.start = start;  assign if4.op = op;  assign if4.a = a;  assign if4.b = b;
  assign if32.start = start; assign if32.op = op; assign if32.a = a; assign if32.b = b;
  logic_unit_seq #(.WIDTH(32), .LANE(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(if8));
  logic_unit_seq #(.WIDTH(32), .LANE(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  logic_unit_seq #(.WIDTH(32), .LANE(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input logic ez, input string tag);
    int t8 = 0, t4 = 0, t32 = 0, nb = 0, nd = 0;
    logic [31:0] r8 = 'x, r4 = 'x, r32 = 'x;
    logic z8 = 'x, z4 = 'x, z32 = 'x;
    op = o; a = x; b = y; start = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 0;
      if (if8.busy) nb++;
      if (if8.done) begin
        nd++;
        if (t8 == 0) begin t8 = i; r8 = if8.result; z8 = if8.zero; end
      end
      if (if4.done && t4 == 0) begin t4 = i; r4 = if4.result; z4 = if4.zero; end
      if (if32.done && t32 == 0) begin t32 = i; r32 = if32.result; z32 = if32.zero; end
    end
    chk({tag, " res8"}, r8, er);
    chk({tag, " zero8"}, z8, ez);
    chk({tag, " lat8"}, t8, 5);
    chk({tag, " busy8"}, nb, 4);
    chk({tag, " ndone8"}, nd, 1);
    chk({tag, " res4"}, r4, er);
    chk({tag, " zero4"}, z4, ez);
    chk({tag, " lat4"}, t4, 9);
    chk({tag, " res32"}, r32, er);
    chk({tag, " zero32"}, z32, ez);
    chk({tag, " lat32"}, t32, 2);
  endtask
  initial begin
    int nd, nb, d1, d2;
    logic [31:0] r1, r2;
    logic z1, z2;
    repeat (3) @(negedge clk);
    chk("reset busy", if8.busy, 1'b0);
    chk("reset done", if8.done, 1'b0);
    chk("reset result", if8.result, 32'h0);
    chk("reset zero", if8.zero, 1'b1);
    rst_n = 1;
    @(negedge clk);
    chk("idle no start", if8.busy, 1'b0);
    run(2'b01, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, "or");
    run(2'b00, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, "and0");
    run(2'b10, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, "xor");
    run(2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "nor");
    run(2'b10, 32'h0F0F_00FF, 32'h00FF_0FF0, 32'h0FF0_0F0F, 1'b0, "xor2");
    run(2'b11, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0001, 1'b0, "nor2");
    run(2'b01, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 1'b0, "or2");
    run(2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, "and2");
    op = 2'b01; a = 32'h1; b = 32'h2; start = 1;
    nd = 0; nb = 0; r1 = 'x;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) start = 0;
      if (i == 2) begin a = '1; b = '1; op = 2'b00; start = 1; end
      if (i == 3) start = 0;
      if (if8.busy) nb++;
      if (if8.done) begin nd++; r1 = if8.result; end
    end
    chk("churn result", r1, 32'h3);
    chk("churn ndone", nd, 1);
    chk("churn busy", nb, 4);
    op = 2'b01; a = 32'hFF; b = 32'h0; start = 1;
    @(negedge clk);
    start = 0;
    chk("mid busy", if8.busy, 1'b1);
    @(negedge clk);
    chk("mid partial", if8.result, 32'hFF);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid rst busy", if8.busy, 1'b0);
    chk("mid rst done", if8.done, 1'b0);
    chk("mid rst result", if8.result, 32'h0);
    chk("mid rst zero", if8.zero, 1'b1);
    @(negedge clk);
    chk("mid rst idle", if8.busy, 1'b0);
    run(2'b01, 32'h1, 32'h0, 32'h1, 1'b0, "fresh");
    op = 2'b10; a = 32'h1234_5678; b = 32'hFFFF_0000; start = 1;
    d1 = 0; d2 = 0; r1 = 'x; r2 = 'x; z1 = 'x; z2 = 'x;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin op = 2'b00; a = 32'hF0F0_F0F0; b = 32'h0FF0_0FF0; end
      if (i == 7) start = 0;
      if (if8.done && d1 == 0) begin d1 = i; r1 = if8.result; z1 = if8.zero; end
      else if (if8.done && d2 == 0) begin d2 = i; r2 = if8.result; z2 = if8.zero; end
    end
    chk("b2b done1", d1, 5);
    chk("b2b done2", d2, 11);
    chk("b2b res1", r1, 32'hEDCB_5678);
    chk("b2b res2", r2, 32'h00F0_00F0);
    chk("b2b zero1", z1, 1'b0);
    chk("b2b zero2", z2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
